gobang_judge: RTL
=================

GOBANG_JUDGE -- requirements
Module: gobang_judge

Interface
REQ-001 The block SHALL use parameters BOARD_N=10 (board side), WIN_LEN=5 (stones in a row to win) and CELLS=100 (BOARD_N squared).
REQ-002 The block SHALL have port clk  input  1  system clock, 100 MHz.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port Player_Red  input  100  red occupancy, bit index = row*10+col.
REQ-005 The block SHALL have port Player_Green  input  100  green occupancy, same indexing as Player_Red.
REQ-006 The block SHALL have port flag_player  output  1  side to move: 1=red, 0=green; feeds the placement stage.
REQ-007 The block SHALL have port game_over  output  1  win or draw latched.
REQ-008 The block SHALL have ports red_win, green_win and draw  output  1 each  result flags, at most one set.
REQ-009 The block SHALL have port win_pos  output  7  start cell index of the winning line.
REQ-010 The block SHALL have port win_dir  output  2  direction of the winning line: 0=horizontal (+col), 1=vertical (+row), 2=diagonal (+row,+col), 3=anti-diagonal (+row,-col).
REQ-011 The block SHALL have port busy  output  1  high while in SCAN.

Function
REQ-012 The block SHALL keep prev_r/prev_g registers updated from the inputs every cycle and SHALL raise change = (inputs != prev), a single-cycle pulse per board update.
REQ-013 On each change pulse while not in OVER, the block SHALL toggle flag_player on the next clock edge and set pending.
REQ-014 The FSM SHALL have exactly three states: IDLE, SCAN and OVER.
REQ-015 In IDLE with pending set, the block SHALL capture snap_r/snap_g from the inputs, clear pending, zero row and col, and enter SCAN.
REQ-016 In SCAN, the block SHALL evaluate one cell per cycle: row/col counters (no division), col wraps at 9 to 0 with row+1; a full scan takes 100 cycles.
REQ-017 For each cell, the block SHALL check all four directions for both colours in the same cycle, using only the snapshot.
REQ-018 Direction validity SHALL be: dir0 requires col<=5; dir1 requires row<=5; dir2 requires row<=5 and col<=5; dir3 requires row<=5 and col>=4.
REQ-019 A hit SHALL require all 5 cells to hold the same colour.
REQ-020 On the first hit, the block SHALL latch win_pos=row*10+col, win_dir=lowest-numbered hitting direction, and the colour flag, assert game_over, and enter OVER.
REQ-021 If red and green both hit in the same cycle, red_win SHALL take priority.
REQ-022 When a scan ends at cell 99 with no hit: if (snap_r|snap_g) is all ones, the block SHALL set draw and enter OVER; otherwise it SHALL return to IDLE.
REQ-023 A change during SCAN SHALL set pending and SHALL NOT alter the running scan; IDLE then rescans at once.
REQ-024 In OVER, the block SHALL ignore changes: flag_player frozen, pending not set, outputs held until rst.
REQ-025 Worst-case latency from a change to a result SHALL be 202 cycles (one scan pending behind another).

Reset
REQ-026 On rst, the block SHALL set flag_player=1, clear game_over, red_win, green_win, draw and busy, set win_pos=0 and win_dir=0, clear pending, zero row and col, load prev_r/prev_g from the current inputs (no change pulse after reset), and enter IDLE.
REQ-027 rst SHALL take priority in every state, including mid-SCAN, and any partial scan result SHALL be discarded.

Structure
REQ-028 A shared package SHALL hold BOARD_N, WIN_LEN, CELLS, the state encoding (IDLE, SCAN, OVER) and the direction codes DIR_H, DIR_V, DIR_D, DIR_A.
REQ-029 The per-line test SHALL be a combinational sub-module gobang_line_check with inputs board(100), row, col and dir, and output hit; the block SHALL instantiate it 8 times (4 directions x 2 colours).

Verification
REQ-030 The bench SHALL cover: red at cells 0,1,2,3,4 added one per update -> flag_player toggles each update; after the 5th update red_win=1, win_pos=0, win_dir=0, game_over within 102 cycles.
REQ-031 The bench SHALL cover: green at cells 9,18,27,36,45 -> green_win=1, win_pos=9, win_dir=3.
REQ-032 The bench SHALL cover: red at cells 6,7,8,9 plus 10 (a row wrap) -> no win; game_over=0; busy returns low.
REQ-033 The bench SHALL cover: all 100 cells filled with no five-in-row -> draw=1, red_win=green_win=0.
REQ-034 The bench SHALL cover: a change injected at scan cycle 50 -> the current scan completes, a second scan starts the next cycle, and the result reflects the new board.
REQ-035 The bench SHALL cover: rst asserted mid-SCAN, and a board change after a win -> all outputs reset with flag_player=1 and no change pulse; after a win, a board change leaves flag_player and all flags unchanged.

Source files
------------

// File: rtl/gobang_judge_pkg.sv
// Shared constants, FSM encoding and direction codes for the gobang result judge.
// Cell index convention everywhere: row*BOARD_N + col.
package gobang_judge_pkg;

  localparam int BOARD_N   = 10;
  localparam int WIN_LEN   = 5;
  localparam int CELLS     = BOARD_N * BOARD_N;
  localparam int LAST_IDX  = BOARD_N - 1;
  localparam int LINE_SPAN = BOARD_N - WIN_LEN;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [1:0] DIR_H = 2'd0;
  localparam logic [1:0] DIR_V = 2'd1;
  localparam logic [1:0] DIR_D = 2'd2;
  localparam logic [1:0] DIR_A = 2'd3;

  // row*10 built from shifts so no multiplier or divider is ever inferred.
  function automatic logic [6:0] cell_index(input logic [3:0] row, input logic [3:0] col);
    logic [6:0] r7;
    r7 = {3'b000, row};
    return (r7 << 3) + (r7 << 1) + {3'b000, col};
  endfunction

  function automatic logic [1:0] first_dir(input logic [3:0] hits);
    logic [1:0] d;
    d = DIR_A;
    if (hits[2]) d = DIR_D;
    if (hits[1]) d = DIR_V;
    if (hits[0]) d = DIR_H;
    return d;
  endfunction

endpackage

// File: rtl/gobang_judge_if.sv
// Board-in / result-out bundle between the placement stage and the judge.
interface gobang_judge_if;
  import gobang_judge_pkg::*;

  // No valid/ready: the boards are level signals, and any difference from the
  // previous cycle's value is treated as one board update by the judge.
  logic [CELLS-1:0] Player_Red;
  logic [CELLS-1:0] Player_Green;
  logic             flag_player;
  logic             game_over;
  logic             red_win;
  logic             green_win;
  logic             draw;
  logic [6:0]       win_pos;
  logic [1:0]       win_dir;
  logic             busy;
  state_t           state;

  modport master (
    output Player_Red, Player_Green,
    input  flag_player, game_over, red_win, green_win, draw,
    input  win_pos, win_dir, busy, state
  );

  modport slave (
    input  Player_Red, Player_Green,
    output flag_player, game_over, red_win, green_win, draw,
    output win_pos, win_dir, busy, state
  );

endinterface

// File: rtl/gobang_judge_line_check.sv
// Combinational test: does one colour own all WIN_LEN cells starting at (row,col) in dir?
module gobang_line_check
  import gobang_judge_pkg::*;
(
  input  logic [CELLS-1:0] board,
  input  logic [3:0]       row,
  input  logic [3:0]       col,
  input  logic [1:0]       dir,
  output logic             hit
);

  logic       valid;
  logic [7:0] step;
  logic [7:0] idx;
  logic       all_set;

  always_comb begin
    valid = 1'b0;
    step  = 8'd1;
    case (dir)
      DIR_H: begin
        valid = (col <= 4'(LINE_SPAN));
        step  = 8'd1;
      end
      DIR_V: begin
        valid = (row <= 4'(LINE_SPAN));
        step  = 8'(BOARD_N);
      end
      DIR_D: begin
        valid = (row <= 4'(LINE_SPAN)) && (col <= 4'(LINE_SPAN));
        step  = 8'(BOARD_N + 1);
      end
      DIR_A: begin
        valid = (row <= 4'(LINE_SPAN)) && (col >= 4'(WIN_LEN - 1));
        step  = 8'(BOARD_N - 1);
      end
      default: begin
        valid = 1'b0;
        step  = 8'd1;
      end
    endcase

    // Walking the flat index by a fixed stride equals stepping row/col, as long
    // as the line fits on the board, which valid guarantees.
    idx     = {1'b0, cell_index(row, col)};
    all_set = valid;
    for (int k = 0; k < WIN_LEN; k++) begin
      if (idx < 8'(CELLS)) all_set = all_set & board[idx[6:0]];
      else                 all_set = 1'b0;
      idx = idx + step;
    end
    hit = all_set;
  end

endmodule

// File: rtl/gobang_judge.sv
// Gobang judge: watches both boards, scans a snapshot one cell per cycle after every
// update and latches the first five-in-a-row (red first on a tie) or a full-board draw.
module gobang_judge
  import gobang_judge_pkg::*;
(
  input logic           clk,
  input logic           rst,
  gobang_judge_if.slave bus
);

  logic [CELLS-1:0] prev_r;
  logic [CELLS-1:0] prev_g;
  logic [CELLS-1:0] snap_r;
  logic [CELLS-1:0] snap_g;
  logic             pending;
  logic             change;
  logic [3:0]       row;
  logic [3:0]       col;
  state_t           state;

  logic             flag_player_q;
  logic             game_over_q;
  logic             red_win_q;
  logic             green_win_q;
  logic             draw_q;
  logic [6:0]       win_pos_q;
  logic [1:0]       win_dir_q;
  logic             busy_q;

  logic [3:0]       hit_r;
  logic [3:0]       hit_g;
  logic             last_cell;
  logic             board_full;

  assign change     = (bus.Player_Red != prev_r) || (bus.Player_Green != prev_g);
  assign last_cell  = (row == 4'(LAST_IDX)) && (col == 4'(LAST_IDX));
  assign board_full = &(snap_r | snap_g);

  for (genvar d = 0; d < 4; d++) begin : g_dir
    gobang_line_check u_red (
      .board (snap_r),
      .row   (row),
      .col   (col),
      .dir   (2'(d)),
      .hit   (hit_r[d])
    );
    gobang_line_check u_green (
      .board (snap_g),
      .row   (row),
      .col   (col),
      .dir   (2'(d)),
      .hit   (hit_g[d])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // prev follows the live inputs so whatever board is present is not an update.
      prev_r        <= bus.Player_Red;
      prev_g        <= bus.Player_Green;
      snap_r        <= '0;
      snap_g        <= '0;
      pending       <= 1'b0;
      row           <= 4'd0;
      col           <= 4'd0;
      state         <= IDLE;
      flag_player_q <= 1'b1;
      game_over_q   <= 1'b0;
      red_win_q     <= 1'b0;
      green_win_q   <= 1'b0;
      draw_q        <= 1'b0;
      win_pos_q     <= 7'd0;
      win_dir_q     <= DIR_H;
      busy_q        <= 1'b0;
    end else begin
      prev_r <= bus.Player_Red;
      prev_g <= bus.Player_Green;

      if (change && (state != OVER)) begin
        flag_player_q <= ~flag_player_q;
        pending       <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (pending) begin
            snap_r <= bus.Player_Red;
            snap_g <= bus.Player_Green;
            if (!change) pending <= 1'b0;
            row    <= 4'd0;
            col    <= 4'd0;
            busy_q <= 1'b1;
            state  <= SCAN;
          end
        end

        SCAN: begin
          if (|hit_r) begin
            red_win_q   <= 1'b1;
            win_pos_q   <= cell_index(row, col);
            win_dir_q   <= first_dir(hit_r);
            game_over_q <= 1'b1;
            busy_q      <= 1'b0;
            state       <= OVER;
          end else if (|hit_g) begin
            green_win_q <= 1'b1;
            win_pos_q   <= cell_index(row, col);
            win_dir_q   <= first_dir(hit_g);
            game_over_q <= 1'b1;
            busy_q      <= 1'b0;
            state       <= OVER;
          end else if (last_cell) begin
            busy_q <= 1'b0;
            if (board_full) begin
              draw_q      <= 1'b1;
              game_over_q <= 1'b1;
              state       <= OVER;
            end else begin
              state <= IDLE;
            end
          end else if (col == 4'(LAST_IDX)) begin
            col <= 4'd0;
            row <= row + 4'd1;
          end else begin
            col <= col + 4'd1;
          end
        end

        OVER: begin
        end

        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.flag_player = flag_player_q;
  assign bus.game_over   = game_over_q;
  assign bus.red_win     = red_win_q;
  assign bus.green_win   = green_win_q;
  assign bus.draw        = draw_q;
  assign bus.win_pos     = win_pos_q;
  assign bus.win_dir     = win_dir_q;
  assign bus.busy        = busy_q;
  assign bus.state       = state;

endmodule
